// File: rtl/aes_round_ctrl.sv
// AES round sequencer: accepts a key-size/direction command, steps round 0..Nr, then holds the result until consumed.
// Optional build macro AES_CTRL_STALL_EN adds a round_en input that gates round advancement in RUN.
module aes_round_ctrl #(
    parameter int RW     = 4,
    parameter int NR_128 = 10,
    parameter int NR_192 = 12,
    parameter int NR_256 = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [1:0]    mode,
    input  logic          enc_dec,
    input  logic          abort,
`ifdef AES_CTRL_STALL_EN
    input  logic          round_en,
`endif
    output logic [RW-1:0] round,
    output logic [RW-1:0] key_idx,
    output logic          first_round,
    output logic          last_round,
    output logic          busy,
    output logic [1:0]    mode_reg,
    output logic          enc_dec_reg,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          err
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;

    generate
        if ((2 ** RW) <= NR_256) begin : g_rw_check
            $error("aes_round_ctrl: RW too narrow for NR_256");
        end
    endgenerate

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic [RW-1:0] nr_q, nr_d;
    logic [1:0]    mode_q, mode_d;
    logic          enc_dec_q, enc_dec_d;
    logic          err_q, err_d;
    logic          step_s;

`ifdef AES_CTRL_STALL_EN
    assign step_s = round_en;
`else
    assign step_s = 1'b1;
`endif

    // Next-state logic; abort overrides every other event.
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        nr_d      = nr_q;
        mode_d    = mode_q;
        enc_dec_d = enc_dec_q;
        err_d     = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            round_d = {RW{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_valid) begin
                        if (mode == 2'b11) begin
                            err_d = 1'b1;
                        end else begin
                            mode_d    = mode;
                            enc_dec_d = enc_dec;
                            round_d   = {RW{1'b0}};
                            state_d   = S_RUN;
                            case (mode)
                                2'b00:   nr_d = RW'(NR_128);
                                2'b01:   nr_d = RW'(NR_192);
                                default: nr_d = RW'(NR_256);
                            endcase
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (step_s) begin
                        if (round_q == nr_q) begin
                            state_d = S_HOLD;
                        end else begin
                            round_d = round_q + {{(RW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        round_d = round_q;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                        round_d = {RW{1'b0}};
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    round_d = {RW{1'b0}};
                end
            endcase
        end
    end

    // State and latched command registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            round_q   <= {RW{1'b0}};
            nr_q      <= {RW{1'b0}};
            mode_q    <= 2'b00;
            enc_dec_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            nr_q      <= nr_d;
            mode_q    <= mode_d;
            enc_dec_q <= enc_dec_d;
            err_q     <= err_d;
        end
    end

    // Decryption walks the key schedule backwards; IDLE presents index 0.
    assign key_idx     = (state_q == S_IDLE) ? {RW{1'b0}} :
                         (enc_dec_q ? round_q : (nr_q - round_q));
    assign start_ready = (state_q == S_IDLE) && !abort;
    assign round       = round_q;
    assign first_round = (state_q == S_RUN) && (round_q == {RW{1'b0}});
    assign last_round  = (state_q == S_RUN) && (round_q == nr_q);
    assign busy        = (state_q != S_IDLE);
    assign out_valid   = (state_q == S_HOLD);
    assign mode_reg    = mode_q;
    assign enc_dec_reg = enc_dec_q;
    assign err         = err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: table of per-cycle vectors plus looped full operations.
module tb_aes_round_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_valid = 1'b0;
    logic       start_ready;
    logic [1:0] mode = 2'b00;
    logic       enc_dec = 1'b0;
    logic       abort = 1'b0;
    logic       round_en = 1'b1;
    logic [3:0] round;
    logic [3:0] key_idx;
    logic       first_round, last_round, busy, enc_dec_reg, out_valid, err;
    logic [1:0] mode_reg;
    logic       out_ready = 1'b0;

    int n_vec = 0;
    int n_bad = 0;
    logic [1:0] cur_md = 2'b00;
    logic       cur_ed = 1'b0;

    aes_round_ctrl #(.RW(4), .NR_128(10), .NR_192(12), .NR_256(14)) dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
        .mode(mode), .enc_dec(enc_dec), .abort(abort),
`ifdef AES_CTRL_STALL_EN
        .round_en(round_en),
`endif
        .round(round), .key_idx(key_idx), .first_round(first_round), .last_round(last_round),
        .busy(busy), .mode_reg(mode_reg), .enc_dec_reg(enc_dec_reg),
        .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic [1:0] md;
        logic       ed;
        logic       ab;
        logic       ordy;
        logic [16:0] exp;
    } vec_t;

    // {sr,busy,ov,err,fr,lr,edr,mdr[1:0],round[3:0],key_idx[3:0]}
    function automatic logic [16:0] pk(input logic sr, input logic bz, input logic ov,
                                       input logic er, input logic fr, input logic lr,
                                       input logic edr, input logic [1:0] mdr,
                                       input logic [3:0] rnd, input logic [3:0] kid);
        return {sr, bz, ov, er, fr, lr, edr, mdr, rnd, kid};
    endfunction

    task automatic step(input logic sv, input logic [1:0] md, input logic ed, input logic ab,
                        input logic ordy, input logic ren, input logic [16:0] exp, input string nm);
        logic [16:0] act;
        @(negedge clk);
        start_valid = sv; mode = md; enc_dec = ed; abort = ab; out_ready = ordy; round_en = ren;
        #1;
        act = {start_ready, busy, out_valid, err, first_round, last_round, enc_dec_reg,
               mode_reg, round, key_idx};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %05h expected %05h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] md, input logic ed, input int nr, input int hold_n,
                          input int stall_r, input int stall_n);
        logic [3:0] kid;
        step(1'b1, md, ed, 1'b0, 1'b0, 1'b1,
             pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur_ed, cur_md, 4'd0, 4'd0), "accept");
        cur_md = md;
        cur_ed = ed;
        for (int r = 0; r <= nr; r++) begin
            kid = ed ? 4'(r) : 4'(nr - r);
            if (r == stall_r) begin
                for (int s = 0; s < stall_n; s++) begin
                    step(1'b0, ~md, ~ed, 1'b0, 1'b0, 1'b0,
                         pk(1'b0, 1'b1, 1'b0, 1'b0, r == 0, r == nr, ed, md, 4'(r), kid), "stall");
                end
            end
            step(1'b0, ~md, ~ed, 1'b0, 1'b1, 1'b1,
                 pk(1'b0, 1'b1, 1'b0, 1'b0, r == 0, r == nr, ed, md, 4'(r), kid), "run");
        end
        kid = ed ? 4'(nr) : 4'd0;
        for (int h = 0; h < hold_n; h++) begin
            step(1'b1, 2'b11, ed, 1'b0, 1'b0, 1'b1,
                 pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ed, md, 4'(nr), kid), "hold_wait");
        end
        step(1'b0, md, ed, 1'b0, 1'b1, 1'b1,
             pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ed, md, 4'(nr), kid), "hold_take");
        step(1'b0, md, ed, 1'b0, 1'b0, 1'b1,
             pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ed, md, 4'd0, 4'd0), "idle_after");
    endtask

    vec_t tbl[16];

    initial begin
        //          sv     md     ed    ab    ordy  expected
        tbl[0]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(1,0,0,0,0,0,0,2'd0,4'd0,4'd0)};
        tbl[1]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, pk(1,0,0,0,0,0,0,2'd0,4'd0,4'd0)};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(1,0,0,1,0,0,0,2'd0,4'd0,4'd0)};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(1,0,0,0,0,0,0,2'd0,4'd0,4'd0)};
        tbl[4]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0, pk(0,0,0,0,0,0,0,2'd0,4'd0,4'd0)};
        tbl[5]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, pk(1,0,0,0,0,0,0,2'd0,4'd0,4'd0)};
        tbl[6]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, pk(0,1,0,0,1,0,1,2'd0,4'd0,4'd0)};
        tbl[7]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(0,1,0,0,0,0,1,2'd0,4'd1,4'd1)};
        tbl[8]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(0,1,0,0,0,0,1,2'd0,4'd2,4'd2)};
        tbl[9]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, pk(0,1,0,0,0,0,1,2'd0,4'd3,4'd3)};
        tbl[10] = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b0, pk(0,1,0,0,0,0,1,2'd0,4'd4,4'd4)};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 1'b1, 1'b0, pk(0,1,0,0,0,0,1,2'd0,4'd5,4'd5)};
        tbl[12] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, pk(1,0,0,0,0,0,1,2'd0,4'd0,4'd0)};
        tbl[13] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(0,1,0,0,1,0,0,2'd1,4'd0,4'd12)};
        tbl[14] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, pk(0,1,0,0,0,0,0,2'd1,4'd1,4'd11)};
        tbl[15] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pk(1,0,0,0,0,0,0,2'd1,4'd0,4'd0)};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].sv, tbl[i].md, tbl[i].ed, tbl[i].ab, tbl[i].ordy, 1'b1,
                 tbl[i].exp, $sformatf("tbl[%0d]", i));
        end
        cur_md = 2'd1;
        cur_ed = 1'b0;

        run_op(2'd0, 1'b1, 10, 0, -1, 0);
        run_op(2'd2, 1'b0, 14, 0, -1, 0);
        run_op(2'd1, 1'b1, 12, 3, -1, 0);
`ifdef AES_CTRL_STALL_EN
        run_op(2'd0, 1'b1, 10, 0, 4, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Parametrised AES round sequencer with a valid/ready command handshake and a valid/ready result handshake. It latches key size (128/192/256) and direction at command accept, then steps the round counter through 0..Nr. It drives round/key-schedule indices, first/last-round flags and a held completion. It sits between the host command interface and the round datapath/key-expansion block.

Parameters:
RW, 4, width of round and key_idx outputs; elaboration error if 2**RW <= NR_256
NR_128, 10, final round index for mode 2'b00
NR_192, 12, final round index for mode 2'b01
NR_256, 14, final round index for mode 2'b10

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start_valid  in  1  command valid
start_ready  out  1  command accepted when start_valid && start_ready
mode  in  2  key size: 00=128, 01=192, 10=256, 11=illegal
enc_dec  in  1  1=encrypt, 0=decrypt; sampled with command
abort  in  1  synchronous cancel of any operation
round  out  RW  current round index
key_idx  out  RW  round-key index to fetch
first_round  out  1  round==0 while RUN
last_round  out  1  round==Nr while RUN
busy  out  1  state != IDLE
mode_reg  out  2  latched mode
enc_dec_reg  out  1  latched direction
out_valid  out  1  result available
out_ready  in  1  result consumed when out_valid && out_ready
err  out  1  one-cycle pulse on illegal-mode command

Behaviour:
- Reset: state IDLE; round, key_idx, mode_reg, enc_dec_reg, nr_reg = 0; err, out_valid, busy, first_round, last_round = 0.
- States: IDLE, RUN, HOLD. start_ready = (state==IDLE) && !abort.
- IDLE, command accepted, mode != 11: latch mode_reg, enc_dec_reg; nr_reg = NR_x; round = 0; go to RUN.
- IDLE, command accepted, mode == 11: err=1 for the next cycle only; no state change; latched registers unchanged.
- RUN: round increments by 1 each cycle. key_idx = enc_dec_reg ? round : nr_reg - round, computed combinationally at RW bits.
- RUN, round == nr_reg: next state HOLD; round holds at nr_reg.
- HOLD: out_valid=1, held until out_valid && out_ready; then next state IDLE, round and key_idx return to 0. mode_reg and enc_dec_reg keep their values until the next accepted command.
- Latency, command accepted at edge T:
  - round 0 visible in cycle T+1
  - round Nr visible in cycle T+1+Nr
  - out_valid first high in cycle T+2+Nr
  - AES128: 11 RUN cycles. AES192: 13. AES256: 15.
- Inputs mode/enc_dec are ignored outside command accept; changes mid-operation have no effect.
- abort (any state): next cycle IDLE, round = 0, out_valid = 0, no err. abort in IDLE blocks command accept. Priority: reset > abort > all other events.
- out_ready while not HOLD: ignored.
- No back-to-back overlap: a new command is accepted no earlier than the cycle after the HOLD handshake.

Optional Feature:
AES_CTRL_STALL_EN:
- Defined: adds input round_en (1 bit). In RUN, round advances and the RUN->HOLD transition occurs only in cycles with round_en=1. All outputs hold while round_en=0. round_en is ignored in IDLE and HOLD. abort still takes effect immediately.
- Undefined: port absent; behaves as round_en tied to 1.

Test Plan:
- Reset, then mode=00, enc_dec=1, start pulse -> round 0..10 in consecutive cycles, key_idx = round, first_round at round 0, last_round at round 10, out_valid next cycle, busy high throughout.
- mode=10, enc_dec=0 -> 15 RUN cycles; key_idx 14,13,...,0; last_round when round=14, key_idx=0.
- mode=11 with start_valid -> err high exactly one cycle; busy stays 0; start_ready stays 1; mode_reg unchanged.
- mode=01 with out_ready held low 3 cycles after completion -> out_valid high 3+ cycles, round stays 12; start_valid ignored in HOLD (start_ready=0); IDLE after handshake.
- abort asserted at round 5 of AES128, with mode toggled to 10 at round 3 -> nr unchanged until abort; IDLE next cycle, round=0, no out_valid; a new command is accepted the following cycle.
- With AES_CTRL_STALL_EN: AES128, round_en low for 2 cycles at round 4 -> round holds at 4 for 2 extra cycles; out_valid arrives 2 cycles later than nominal.
